snake_move_ctrl: RTL and testbench

//  Sequences the snake head square drawn by the VGA pixel-colour stage: holds box_x/box_y and the

---
 rtl/snake_move_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl
//   Moves the snake head square shown by the VGA colour stage. It holds the
//   head position box_x/box_y, the committed direction and the game-over flag.
//   The head advances one BLOCK_W cell every STEP_FRAMES video frames.
//   Position updates happen only on frame_start, so a frame never shows a
//   half-moved square. Everything runs in the vga_clk domain.
//
//   Optional build macro: SNAKE_WRAP_EN. When it is defined, the walls wrap to
//   the opposite edge and the game never ends. When it is undefined, hitting a
//   wall ends the game (state OVER, fin=1).
//
// Ports
//   vga_clk      in   1   pixel clock, the only clock
//   sys_rst      in   1   synchronous active-high reset
//   frame_start  in   1   one-cycle pulse at start of vertical blank
//   key_up/down/left/right in 1  one-cycle debounced direction pulses
//   key_start    in   1   start / pause / resume / restart pulse
//   box_x        out  10  head left edge, pixels
//   box_y        out  10  head top edge, pixels
//   dir          out  2   committed direction 0=up 1=down 2=left 3=right
//   fin          out  1   game over
//   running      out  1   high while in RUN
module snake_move_ctrl #(
  parameter int H_DISP      = 800,
  parameter int V_DISP      = 600,
  parameter int BLOCK_W     = 10,
  parameter int STEP_FRAMES = 6,
  parameter int START_X     = 400,
  parameter int START_Y     = 300
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic       frame_start,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_start,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic [1:0] dir,
  output logic       fin,
  output logic       running
);

  localparam int CNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_FRAMES - 1);

  localparam logic [10:0] BW     = 11'(BLOCK_W);
  localparam logic [10:0] BW2    = 11'(2 * BLOCK_W);
  localparam logic [10:0] HD     = 11'(H_DISP);
  localparam logic [10:0] VD     = 11'(V_DISP);
  localparam logic [10:0] X_LAST = 11'(H_DISP - BLOCK_W);
  localparam logic [10:0] Y_LAST = 11'(V_DISP - BLOCK_W);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;
  logic [1:0]       pend_dir, pend_dir_nxt, dir_nxt, pend_eff, key_dir;
  logic [9:0]       box_x_nxt, box_y_nxt;
  logic [10:0]      bx, by, nx, ny;
  logic             key_vld, key_rev, at_edge, collide, step_fire;

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
      box_x     <= 10'(START_X);
      box_y     <= 10'(START_Y);
      dir       <= DIR_RIGHT;
      pend_dir  <= DIR_RIGHT;
      fin       <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_cnt_nxt;
      box_x     <= box_x_nxt;
      box_y     <= box_y_nxt;
      dir       <= dir_nxt;
      pend_dir  <= pend_dir_nxt;
      fin       <= (state_nxt == OVER);
      running   <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    box_x_nxt     = box_x;
    box_y_nxt     = box_y;
    dir_nxt       = dir;

    // Fixed same-cycle priority up > down > left > right.
    key_vld = key_up | key_down | key_left | key_right;
    if (key_up)        key_dir = DIR_UP;
    else if (key_down) key_dir = DIR_DOWN;
    else if (key_left) key_dir = DIR_LEFT;
    else               key_dir = DIR_RIGHT;

    // Opposite directions share bit 1 and differ in bit 0. Reversal is
    // judged against the committed direction, not the pending one.
    key_rev  = (key_dir == {dir[1], ~dir[0]});
    pend_eff = ((state == RUN || state == PAUSE) && key_vld && !key_rev)
               ? key_dir : pend_dir;
    pend_dir_nxt = pend_eff;

    // The next position is computed in 11 bits so that the down/right edge
    // tests cannot overflow.
    bx = {1'b0, box_x};
    by = {1'b0, box_y};
    nx = bx;
    ny = by;
    unique case (pend_eff)
      DIR_UP: begin
        at_edge = (by < BW);
        ny      = at_edge ? Y_LAST : by - BW;
      end
      DIR_DOWN: begin
        at_edge = (by + BW2 > VD);
        ny      = at_edge ? 11'd0 : by + BW;
      end
      DIR_LEFT: begin
        at_edge = (bx < BW);
        nx      = at_edge ? X_LAST : bx - BW;
      end
      default: begin
        at_edge = (bx + BW2 > HD);
        nx      = at_edge ? 11'd0 : bx + BW;
      end
    endcase
`ifdef SNAKE_WRAP_EN
    collide = 1'b0;
`else
    collide = at_edge;
`endif

    step_fire = (state == RUN) && frame_start && (frame_cnt == CNT_LAST);

    unique case (state)
      IDLE: begin
        frame_cnt_nxt = '0;
        if (key_start) state_nxt = RUN;
      end
      RUN: begin
        if (frame_start)
          frame_cnt_nxt = (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
        // A start/pause press beats a step that lands in the same cycle.
        if (key_start) begin
          state_nxt = PAUSE;
        end else if (step_fire) begin
          dir_nxt = pend_eff;
          if (collide) begin
            state_nxt = OVER;
          end else begin
            box_x_nxt = nx[9:0];
            box_y_nxt = ny[9:0];
          end
        end
      end
      PAUSE: begin
        if (key_start) state_nxt = RUN;
      end
      default: begin
        frame_cnt_nxt = '0;
        if (key_start) begin
          state_nxt    = IDLE;
          box_x_nxt    = 10'(START_X);
          box_y_nxt    = 10'(START_Y);
          dir_nxt      = DIR_RIGHT;
          pend_dir_nxt = DIR_RIGHT;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_snake_move_ctrl.sv
module tb_snake_move_ctrl;

  logic       vga_clk = 1'b0;
  logic       sys_rst, frame_start, key_up, key_down, key_left, key_right, key_start;
  logic [9:0] box_x, box_y;
  logic [1:0] dir;
  logic       fin, running;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] d;
    logic       f;
    logic       r;
  } exp_t;

  exp_t exp_q[$];

  snake_move_ctrl dut (
    .vga_clk     (vga_clk),
    .sys_rst     (sys_rst),
    .frame_start (frame_start),
    .key_up      (key_up),
    .key_down    (key_down),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_start   (key_start),
    .box_x       (box_x),
    .box_y       (box_y),
    .dir         (dir),
    .fin         (fin),
    .running     (running)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs from a negedge, then return at the next negedge.
  task automatic tick(input logic rst, input logic fs, input logic u, input logic d,
                      input logic l, input logic r, input logic s);
    sys_rst = rst; frame_start = fs; key_up = u; key_down = d;
    key_left = l; key_right = r; key_start = s;
    @(negedge vga_clk);
    sys_rst = 0; frame_start = 0; key_up = 0; key_down = 0;
    key_left = 0; key_right = 0; key_start = 0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) tick(0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic push_exp(input string tag, input int x, input int y, input int d,
                          input logic f, input logic r);
    exp_t e;
    e.tag = tag; e.x = 10'(x); e.y = 10'(y); e.d = 2'(d); e.f = f; e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({e.tag, ".box_x"},   box_x,   e.x);
    chk({e.tag, ".box_y"},   box_y,   e.y);
    chk({e.tag, ".dir"},     dir,     e.d);
    chk({e.tag, ".fin"},     fin,     e.f);
    chk({e.tag, ".running"}, running, e.r);
  endtask

  initial begin
    sys_rst = 1; frame_start = 0; key_up = 0; key_down = 0;
    key_left = 0; key_right = 0; key_start = 0;
    @(negedge vga_clk);

    // Reset
    push_exp("reset", 400, 300, 3, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    pop_cmp();

    // T1: start, then a step after six frames
    push_exp("t1_start", 400, 300, 3, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 1);
    pop_cmp();
    push_exp("t1_5frames", 400, 300, 3, 0, 1);
    frames(5);
    pop_cmp();
    push_exp("t1_step", 410, 300, 3, 0, 1);
    frames(1);
    pop_cmp();
    push_exp("t1_hold", 410, 300, 3, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 0);
    pop_cmp();

    // T2: reversal ignored, up beats down in the same cycle
    tick(0, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 1, 1, 0, 0, 0);
    push_exp("t2_up", 410, 290, 0, 0, 1);
    frames(6);
    pop_cmp();
    // last accepted key wins: left then right (both legal while going up)
    tick(0, 0, 0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0, 1, 0);
    push_exp("t2_lastwins", 420, 290, 3, 0, 1);
    frames(6);
    pop_cmp();
    // left while going right is a reversal
    tick(0, 0, 0, 0, 1, 0, 0);
    push_exp("t2_reverse", 430, 290, 3, 0, 1);
    frames(6);
    pop_cmp();

    // T3: run to the right wall
    push_exp("t3_at790", 790, 290, 3, 0, 1);
    frames(36 * 6);
    pop_cmp();
`ifdef SNAKE_WRAP_EN
    push_exp("t3_wrap_right", 0, 290, 3, 0, 1);
    frames(6);
    pop_cmp();
    tick(0, 0, 1, 0, 0, 0, 0);
    push_exp("t3_wrap_up", 0, 280, 0, 0, 1);
    frames(6);
    pop_cmp();
    tick(0, 0, 0, 0, 1, 0, 0);
    push_exp("t6_wrap_left", 790, 280, 2, 0, 1);
    frames(6);
    pop_cmp();
    push_exp("t3_rst", 400, 300, 3, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    pop_cmp();
`else
    push_exp("t3_hit", 790, 290, 3, 1, 0);
    frames(6);
    pop_cmp();
    tick(0, 0, 1, 0, 0, 0, 0);
    push_exp("t3_over_hold", 790, 290, 3, 1, 0);
    frames(6);
    pop_cmp();
    push_exp("t3_restart", 400, 300, 3, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    pop_cmp();
`endif

    // T4: pause mid-count, keys still accepted, count resumes
    push_exp("t4_run", 400, 300, 3, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 1);
    pop_cmp();
    frames(3);
    push_exp("t4_pause", 400, 300, 3, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    pop_cmp();
    tick(0, 0, 1, 0, 0, 0, 0);
    push_exp("t4_paused20", 400, 300, 3, 0, 0);
    frames(20);
    pop_cmp();
    push_exp("t4_resume", 400, 300, 3, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 1);
    pop_cmp();
    push_exp("t4_2frames", 400, 300, 3, 0, 1);
    frames(2);
    pop_cmp();
    push_exp("t4_step", 400, 290, 0, 0, 1);
    frames(1);
    pop_cmp();

    // T5: key_start wins over a step in the same cycle; reset during RUN
    frames(5);
    push_exp("t5_start_vs_step", 400, 290, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 1);
    pop_cmp();
    push_exp("t5_resume", 400, 290, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 1);
    pop_cmp();
    push_exp("t5_rst_run", 400, 300, 3, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    pop_cmp();

    // Direction key in the step cycle takes effect in that step
    tick(0, 0, 0, 0, 0, 0, 1);
    frames(5);
    push_exp("t5_key_in_step", 400, 290, 0, 0, 1);
    tick(0, 1, 1, 0, 0, 0, 0);
    pop_cmp();
    push_exp("t5_top", 400, 0, 0, 0, 1);
    frames(29 * 6);
    pop_cmp();
`ifdef SNAKE_WRAP_EN
    push_exp("t5_wrap_top", 400, 590, 0, 0, 1);
`else
    push_exp("t5_hit_top", 400, 0, 0, 1, 0);
`endif
    frames(6);
    pop_cmp();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
